// File: rtl/i2c_mux_pkg.sv
// Shared types and sizing for the I2C return-path multiplexer.
package i2c_mux_pkg;

  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

endpackage

// File: rtl/i2c_cond_detect.sv
// Input synchronizers for upstream SCL/SDA and every segment SDA, plus
// START/STOP condition detection as single-cycle pulses.
module i2c_cond_detect
  import i2c_mux_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                scl_raw,
  input  logic                sda_raw,
  input  logic [CHANNELS-1:0] seg_sda_raw,
  output logic                scl_s,
  output logic                sda_s,
  output logic [CHANNELS-1:0] seg_sda_s,
  output logic                start_pulse,
  output logic                stop_pulse
);

  localparam int W = CHANNELS + 2;

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync_d [SYNC_STAGES];
  logic [1:0]   prev_q, prev_d;  // {scl, sda} one sample behind the sync output

  always_comb begin
    sync_d[0] = {scl_raw, sda_raw, seg_sda_raw};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[SYNC_STAGES-1][W-1 -: 2];
  end

  // NOTE: reset loads "released" (1) into every stage so that leaving reset
  // can never look like an SDA falling edge, i.e. a spurious START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      prev_q <= '1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value
      // of its predecessor, which is what makes this a shift chain.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q <= prev_d;
    end
  end

  assign {scl_s, sda_s, seg_sda_s} = sync_q[SYNC_STAGES-1];

  assign start_pulse = prev_q[1] & scl_s & prev_q[0] & ~sda_s;
  assign stop_pulse  = scl_s & ~prev_q[0] & sda_s;

endmodule

// File: rtl/i2c_return_mux.sv
// Selects which downstream segment's SDA is returned to the master, and only
// re-targets the select between transactions (after STOP or idle timeout).
module i2c_return_mux
  import i2c_mux_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclIn,
  input  logic                sdaMaster,
  input  logic [CHANNELS-1:0] sdaIn,
  input  logic [SEL_W-1:0]    selReq,
  input  logic                selValid,
  output logic                selReady,
  output logic [SEL_W-1:0]    select,
  output logic                sdaOut,
  output logic                busBusy,
  output logic                switchDone
);

  localparam int              CNT_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    select_q, select_d;
  logic [SEL_W-1:0]    pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic                sda_out_q, sda_out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                scl_s, sda_s, start_p, stop_p;
  logic [CHANNELS-1:0] seg_sda_s;
  logic                accept, have_req, bus_free;
  logic [SEL_W-1:0]    req_val;

  i2c_cond_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk         (clk),
    .reset_n     (reset_n),
    .scl_raw     (sclIn),
    .sda_raw     (sdaMaster),
    .seg_sda_raw (sdaIn),
    .scl_s       (scl_s),
    .sda_s       (sda_s),
    .seg_sda_s   (seg_sda_s),
    .start_pulse (start_p),
    .stop_pulse  (stop_p)
  );

  // A request arriving in the same cycle as the bus frees up is used directly.
  assign accept   = selValid & ~pend_valid_q;
  assign have_req = pend_valid_q | accept;
  assign req_val  = pend_valid_q ? pend_q : selReq;
  assign bus_free = stop_p | (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    select_d     = select_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = '0;

    if (accept) begin
      pend_d       = selReq;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_p)       state_d = ST_BUSY;
        else if (have_req) state_d = ST_SWITCH;
      end
      ST_BUSY: begin
        if (bus_free)            state_d = have_req ? ST_SWITCH : ST_IDLE;
        else if (scl_s && sda_s) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      ST_SWITCH: begin
        state_d      = ST_IDLE;
        pend_valid_d = 1'b0;
        pend_d       = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // select is loaded on the edge into SWITCH so it is visible during SWITCH.
    if (state_d == ST_SWITCH && state_q != ST_SWITCH) select_d = req_val;

    sda_out_d = (state_d == ST_SWITCH) ? 1'b1 : seg_sda_s[select_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      select_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      sda_out_q    <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      sda_out_q    <= sda_out_d;
      cnt_q        <= cnt_d;
    end
  end

  assign selReady   = ~pend_valid_q;
  assign select     = select_q;
  assign sdaOut     = sda_out_q;
  assign busBusy    = (state_q == ST_BUSY);
  assign switchDone = (state_q == ST_SWITCH);

endmodule

// File: doc/i2c_return_mux.md
I2C_RETURN_MUX -- requirements
Module: i2c_return_mux

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on every asynchronous input.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1000, count of clk cycles with SCL and SDA both high that forces bus idle.
REQ-003 SHALL have port clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sclIn  input  1  upstream SCL as driven by the master.
REQ-006 SHALL have port sdaMaster  input  1  upstream SDA as driven by the master.
REQ-007 SHALL have port sdaIn  input  8  sampled SDA of each downstream segment; 1 = released.
REQ-008 SHALL have port selReq  input  3  requested channel.
REQ-009 SHALL have port selValid  input  1  request strobe; accepted when selValid and selReady are both 1.
REQ-010 SHALL have port selReady  output  1  1 = no request pending.
REQ-011 SHALL have port select  output  3  active channel, feeding the downstream demux select.
REQ-012 SHALL have port sdaOut  output  1  returned SDA toward the master; 1 = released.
REQ-013 SHALL have port busBusy  output  1  1 = transaction in progress between START and STOP.
REQ-014 SHALL have port switchDone  output  1  one-cycle pulse when select takes a new value.

Function
REQ-015 SHALL pass sclIn, sdaMaster and sdaIn through SYNC_STAGES flops before any use.
REQ-016 SHALL detect START as synchronized SDA falling while synchronized SCL is high, on both the previous and the current sample.
REQ-017 SHALL detect STOP as synchronized SDA rising while synchronized SCL is high.
REQ-018 SHALL implement states IDLE, BUSY and SWITCH.
REQ-019 In IDLE, SHALL go to BUSY on START.
REQ-020 In IDLE, an accepted request without START SHALL go to SWITCH on the next cycle.
REQ-021 In BUSY, SHALL go to SWITCH on STOP or timeout if a request is pending, else to IDLE.
REQ-022 SWITCH SHALL last exactly one cycle and then go to IDLE.
REQ-023 An accepted request SHALL be latched into a pending register; selReady SHALL be 0 from the cycle after acceptance until SWITCH completes.
REQ-024 A selValid received while selReady is 0 SHALL be ignored, with no effect on the pending value.
REQ-025 In SWITCH, select SHALL load the pending value, switchDone SHALL be 1, sdaOut SHALL be forced to 1, and the pending register SHALL clear.
REQ-026 Latency from an IDLE acceptance at cycle N SHALL be: select updated and switchDone high at N+1, IDLE at N+2, selReady 1 at N+2.
REQ-027 A request equal to the current select SHALL still pass through SWITCH and pulse switchDone.
REQ-028 Outside SWITCH, sdaOut SHALL equal the synchronized sdaIn[select] (registered, 1 cycle).
REQ-029 When START and an accepted request occur in the same IDLE cycle, START SHALL win: go to BUSY and hold the request pending.
REQ-030 When STOP and an accepted request occur in the same BUSY cycle, the request SHALL be applied via that STOP.
REQ-031 The timeout counter SHALL count while in BUSY with synchronized SCL and SDA both 1.
REQ-032 The timeout counter SHALL clear on any 0 sample or on leaving BUSY.
REQ-033 The timeout counter SHALL saturate; reaching IDLE_TIMEOUT SHALL act as STOP.
REQ-034 busBusy SHALL be 1 exactly in BUSY.
REQ-035 select SHALL never change outside SWITCH.

Reset
REQ-036 While reset_n = 0, SHALL immediately set: state IDLE, select 0, sdaOut 1, busBusy 0, selReady 1, switchDone 0.
REQ-037 While reset_n = 0, SHALL immediately clear the pending register and the timeout counter, and set synchronizer flops to 1.
REQ-038 Reset mid-transaction SHALL discard any pending request.
REQ-039 After reset, SHALL NOT treat the bus as BUSY until a fresh START.

Structure
REQ-040 Package i2c_mux_pkg SHALL hold: state enum, CHANNELS = 8, SEL_W = 3.
REQ-041 Sub-module i2c_cond_detect SHALL contain the synchronizers plus START/STOP detection, emitting one-cycle pulses.

Verification
REQ-042 IDLE, selReq=5 with selValid pulse at cycle N -> select=5 and switchDone=1 at N+1, selReady=1 at N+2.
REQ-043 START, then selReq=3 while BUSY -> select unchanged and selReady=0 until STOP; select=3 one cycle after STOP detected.
REQ-044 select=2, sdaIn=8'b1111_1011 -> sdaOut=0; SWITCH cycle -> sdaOut=1.
REQ-045 START, then SCL=SDA=1 held for 1000 cycles with a pending request -> SWITCH taken; busBusy falls.
REQ-046 START and selValid in the same cycle, then a second selValid while pending -> only the first value is applied after STOP.
REQ-047 reset_n low while BUSY with a request pending -> select=0, selReady=1, busBusy=0 immediately; no switchDone after release.
